// File: rtl/prs_pkg.sv
// prs_pkg -- shared definitions for the PRS burst controller.
//   PRS_INIT_DEFAULT : LFSR seed after reset, also used in place of an all-zero seed
//   PRS_TAP_MASK     : feedback taps s[31], s[30], s[29], s[27], s[25], s[0]
//   prs_state_e      : burst FSM state encoding
//   prs_feedback()   : XOR of the tapped state bits (the next generated bit)
package prs_pkg;

  localparam logic [31:0] PRS_INIT_DEFAULT = 32'h974C_A351;
  localparam logic [31:0] PRS_TAP_MASK     = 32'hEA00_0001;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_GEN  = 3'd2,
    ST_HOLD = 3'd3,
    ST_DONE = 3'd4
  } prs_state_e;

  function automatic logic prs_feedback(input logic [31:0] s);
    return ^(s & PRS_TAP_MASK);
  endfunction

endpackage

// File: rtl/prs_lfsr.sv
// prs_lfsr -- 32-bit Fibonacci LFSR with step enable and synchronous load.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset (state -> INIT_REG)
//   step_i       : advance one step: s <= {fb, s[31:1]}
//   load_i       : load load_val_i (takes priority over step_i)
//   load_val_i   : value to load
//   fb_o         : feedback bit of the current state (the bit the next step shifts in)
module prs_lfsr
  import prs_pkg::*;
#(
  parameter logic [31:0] INIT_REG = PRS_INIT_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        step_i,
  input  logic        load_i,
  input  logic [31:0] load_val_i,
  output logic        fb_o
);

  logic [31:0] state_q;
  logic [31:0] state_d;

  assign fb_o = prs_feedback(state_q);

  always_comb begin
    state_d = state_q;
    if (load_i) begin
      state_d = load_val_i;
    end else if (step_i) begin
      state_d = {fb_o, state_q[31:1]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= INIT_REG;
    end else begin
      state_q <= state_d;
    end
  end

endmodule

// File: rtl/prs_burst_ctrl.sv
// prs_burst_ctrl -- pseudo-random byte burst generator with valid/ready output.
// A burst of len bytes is requested with start (in IDLE). Each byte is built from
// 8 consecutive LFSR feedback bits (first bit in bit 0) over 8 GEN cycles, then
// held in HOLD until the sink accepts it.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   start, len          : burst request and length in bytes (len==0 -> immediate done)
//   seed_ld, seed       : optional per-burst seed, captured with start
//   abort               : drop the burst (LOAD/GEN/HOLD), no done pulse
//   out_data, out_valid : generated byte and its valid flag
//   out_ready           : sink accept; a transfer is out_valid & out_ready
//   busy                : high in LOAD, GEN and HOLD
//   done                : one-cycle pulse at normal burst completion
//   bytes_left          : bytes of the current burst not yet transferred
// Build option: define PRS_BURST_CTRL_SEED_LOAD_EN to honour seed_ld/seed; without it
// the seed ports are ignored and the LFSR runs on across bursts from its reset value.
module prs_burst_ctrl
  import prs_pkg::*;
#(
  parameter logic [31:0] INIT_REG = PRS_INIT_DEFAULT,
  parameter int          LEN_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             seed_ld,
  input  logic [31:0]      seed,
  input  logic             abort,
  output logic [7:0]       out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             done,
  output logic [LEN_W-1:0] bytes_left
);

  prs_state_e       state_q, state_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [7:0]       data_q, data_d;
  logic [LEN_W-1:0] left_q, left_d;

  logic        lfsr_step;
  logic        lfsr_load;
  logic [31:0] lfsr_load_val;
  logic        lfsr_fb;
  logic        xfer;

  assign out_valid  = (state_q == ST_HOLD);
  assign busy       = (state_q == ST_LOAD) || (state_q == ST_GEN) || (state_q == ST_HOLD);
  assign done       = (state_q == ST_DONE);
  assign out_data   = data_q;
  assign bytes_left = left_q;
  assign xfer       = out_valid & out_ready;

  // An abort edge leaves the LFSR exactly where it was, so a later burst
  // without a seed load continues from the last bit actually generated.
  assign lfsr_step = (state_q == ST_GEN) && !abort;

`ifdef PRS_BURST_CTRL_SEED_LOAD_EN
  logic        seed_ld_q, seed_ld_d;
  logic [31:0] seed_q, seed_d;

  always_comb begin
    seed_ld_d = seed_ld_q;
    seed_d    = seed_q;
    if ((state_q == ST_IDLE) && start && (len != '0)) begin
      seed_ld_d = seed_ld;
      seed_d    = seed;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seed_ld_q <= 1'b0;
      seed_q    <= 32'd0;
    end else begin
      seed_ld_q <= seed_ld_d;
      seed_q    <= seed_d;
    end
  end

  assign lfsr_load     = (state_q == ST_LOAD) && seed_ld_q && !abort;
  // An all-zero seed would lock the LFSR up, so substitute the reset seed.
  assign lfsr_load_val = (seed_q == 32'd0) ? INIT_REG : seed_q;
`else
  logic unused_seed;
  assign unused_seed   = ^{seed_ld, seed};
  assign lfsr_load     = 1'b0;
  assign lfsr_load_val = INIT_REG;
`endif

  prs_lfsr #(
    .INIT_REG (INIT_REG)
  ) u_lfsr (
    .clk        (clk),
    .rst_n      (rst_n),
    .step_i     (lfsr_step),
    .load_i     (lfsr_load),
    .load_val_i (lfsr_load_val),
    .fb_o       (lfsr_fb)
  );

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    data_d    = data_q;
    left_d    = left_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (len != '0) begin
            left_d  = len;
            state_d = ST_LOAD;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_LOAD: begin
        if (abort) begin
          left_d  = '0;
          state_d = ST_IDLE;
        end else begin
          bit_cnt_d = 3'd0;
          state_d   = ST_GEN;
        end
      end
      ST_GEN: begin
        if (abort) begin
          left_d  = '0;
          state_d = ST_IDLE;
        end else begin
          // Shifting right for 8 cycles leaves the first bit in bit 0.
          data_d    = {lfsr_fb, data_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            state_d = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        if (abort) begin
          // A transfer on the abort edge still counts as delivered;
          // the remaining count is dropped either way.
          left_d  = '0;
          state_d = ST_IDLE;
        end else if (xfer) begin
          left_d  = left_q - LEN_W'(1);
          state_d = (left_q == LEN_W'(1)) ? ST_DONE : ST_GEN;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= 3'd0;
      data_q    <= 8'd0;
      left_q    <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      data_q    <= data_d;
      left_q    <= left_d;
    end
  end

endmodule
